// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin sequencer that shares one clocked barrel shifter
// between two requesters: the data-processing operand-2 path (requester 0)
// and the load/store scaled-offset path (requester 1). One request is in
// flight at a time. The shifter latency is waited out, then the result is
// returned to the granted requester with a one-cycle pulse.

module shift_arbiter #(
   // Cycles from a shifter-input change to a valid Shift_Out (legal 1..15).
   parameter int SHIFT_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   // requester 0: data-processing operand 2
   input  logic        Req0_Valid,
   output logic        Req0_Ready,
   input  logic [3:1]  Req0_Op,
   input  logic [32:1] Req0_Data,
   input  logic [8:1]  Req0_Num,
   input  logic        Req0_Carry,
   // requester 1: load/store scaled offset
   input  logic        Req1_Valid,
   output logic        Req1_Ready,
   input  logic [3:1]  Req1_Op,
   input  logic [32:1] Req1_Data,
   input  logic [8:1]  Req1_Num,
   input  logic        Req1_Carry,
   // response side
   output logic        Rsp0_Valid,
   output logic        Rsp1_Valid,
   output logic [32:1] Rsp_Out,
   output logic        Rsp_Carry,
   output logic        Busy,
   // shifter side
   output logic [3:1]  SHIFT_OP,
   output logic [32:1] Shift_Data,
   output logic [8:1]  Shift_Num,
   output logic        Carry_flag,
   input  logic [32:1] Shift_Out,
   input  logic        Shift_Carry_Out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Counter load value; the counter is four bits wide, enough for 1..15.
   localparam logic [3:0] LAT_CNT = 4'(SHIFT_LAT);

   state_t      state_q;
   logic        rr_ptr_q;
   logic        owner_q;
   logic [3:0]  cnt_q;
   logic [3:0]  cnt_d;
   logic        busy_q;
   logic        rsp0_q;
   logic        rsp1_q;
   logic [32:1] rsp_out_q;
   logic        rsp_carry_q;

   // Shifter-driving registers and the winner's fields feeding them.
   logic [3:1]  op_q;
   logic [32:1] data_q;
   logic [8:1]  num_q;
   logic        carry_q;
   logic [3:1]  op_d;
   logic [32:1] data_d;
   logic [8:1]  num_d;
   logic        carry_d;

   logic        grant0;
   logic        grant1;

   // Grant: only in IDLE and never while reset is held; rr_ptr breaks ties.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if ((state_q == IDLE) && !rst) begin
         if (Req0_Valid && Req1_Valid) begin
            grant0 = ~rr_ptr_q;
            grant1 = rr_ptr_q;
         end else begin
            grant0 = Req0_Valid;
            grant1 = Req1_Valid;
         end
      end
   end

   // Operand mux: forward the winning requester's fields to the shifter.
   always_comb begin
      op_d    = Req0_Op;
      data_d  = Req0_Data;
      num_d   = Req0_Num;
      carry_d = Req0_Carry;
      if (grant1) begin
         op_d    = Req1_Op;
         data_d  = Req1_Data;
         num_d   = Req1_Num;
         carry_d = Req1_Carry;
      end
   end

   assign cnt_d = cnt_q - 4'd1;

   // Sequencer FSM: accept in IDLE, count down the latency in WAIT, capture
   // on the last WAIT edge, pulse the owner's response in RESP.
   // Shifter inputs are not cleared after RESP to avoid needless toggling.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= 1'b0;
         owner_q     <= 1'b0;
         cnt_q       <= 4'd0;
         busy_q      <= 1'b0;
         rsp0_q      <= 1'b0;
         rsp1_q      <= 1'b0;
         rsp_out_q   <= '0;
         rsp_carry_q <= 1'b0;
         op_q        <= '0;
         data_q      <= '0;
         num_q       <= '0;
         carry_q     <= 1'b0;
      end else begin
         rsp0_q <= 1'b0;
         rsp1_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant0 || grant1) begin
                  op_q     <= op_d;
                  data_q   <= data_d;
                  num_q    <= num_d;
                  carry_q  <= carry_d;
                  owner_q  <= grant1;
                  rr_ptr_q <= ~grant1;
                  cnt_q    <= LAT_CNT;
                  busy_q   <= 1'b1;
                  state_q  <= WAIT;
               end
            end
            WAIT: begin
               cnt_q <= cnt_d;
               if (cnt_q == 4'd1) begin
                  rsp_out_q   <= Shift_Out;
                  rsp_carry_q <= Shift_Carry_Out;
                  rsp0_q      <= ~owner_q;
                  rsp1_q      <= owner_q;
                  state_q     <= RESP;
               end
            end
            RESP: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign Req0_Ready = grant0;
   assign Req1_Ready = grant1;
   assign Rsp0_Valid = rsp0_q;
   assign Rsp1_Valid = rsp1_q;
   assign Rsp_Out    = rsp_out_q;
   assign Rsp_Carry  = rsp_carry_q;
   assign Busy       = busy_q;
   assign SHIFT_OP   = op_q;
   assign Shift_Data = data_q;
   assign Shift_Num  = num_q;
   assign Carry_flag = carry_q;

   // Invariants: at most one grant, never two responses, Busy tracks state.
   a_ready_onehot : assert property (@(posedge clk) disable iff (rst)
      !(Req0_Ready && Req1_Ready));
   a_rsp_onehot : assert property (@(posedge clk) disable iff (rst)
      !(Rsp0_Valid && Rsp1_Valid));
   a_busy_state : assert property (@(posedge clk) disable iff (rst)
      Busy == (state_q != IDLE));

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: one instance with SHIFT_LAT=1 driving a
// combinational shifter model, one with SHIFT_LAT=3 driving a shifter model
// delayed by two register stages (valid when sampled on the third edge).

module tb_shift_arbiter;

   logic clk;
   logic rst;

   // instance a (SHIFT_LAT=1)
   logic        a_Req0_Valid, a_Req0_Ready, a_Req0_Carry;
   logic [3:1]  a_Req0_Op;
   logic [32:1] a_Req0_Data;
   logic [8:1]  a_Req0_Num;
   logic        a_Req1_Valid, a_Req1_Ready, a_Req1_Carry;
   logic [3:1]  a_Req1_Op;
   logic [32:1] a_Req1_Data;
   logic [8:1]  a_Req1_Num;
   logic        a_Rsp0_Valid, a_Rsp1_Valid, a_Rsp_Carry, a_Busy;
   logic [32:1] a_Rsp_Out;
   logic [3:1]  a_SHIFT_OP;
   logic [32:1] a_Shift_Data;
   logic [8:1]  a_Shift_Num;
   logic        a_Carry_flag;
   logic [32:1] a_Shift_Out;
   logic        a_Shift_Carry_Out;

   // instance b (SHIFT_LAT=3)
   logic        b_Req0_Valid, b_Req0_Ready, b_Req0_Carry;
   logic [3:1]  b_Req0_Op;
   logic [32:1] b_Req0_Data;
   logic [8:1]  b_Req0_Num;
   logic        b_Req1_Valid, b_Req1_Ready, b_Req1_Carry;
   logic [3:1]  b_Req1_Op;
   logic [32:1] b_Req1_Data;
   logic [8:1]  b_Req1_Num;
   logic        b_Rsp0_Valid, b_Rsp1_Valid, b_Rsp_Carry, b_Busy;
   logic [32:1] b_Rsp_Out;
   logic [3:1]  b_SHIFT_OP;
   logic [32:1] b_Shift_Data;
   logic [8:1]  b_Shift_Num;
   logic        b_Carry_flag;
   logic [32:1] b_Shift_Out;
   logic        b_Shift_Carry_Out;
   logic [32:0] b_pipe1, b_pipe2;

   int n_tests = 0;
   int n_fail  = 0;

   // ARM-style barrel shifter model; returns {carry, result}.
   function automatic logic [32:0] shf(input logic [2:0] op, input logic [31:0] d,
                                       input logic [7:0] n, input logic c);
      logic [31:0] r;
      logic        co;
      int          s;
      r  = d;
      co = c;
      s  = int'(n);
      case (op[2:1])
         2'b00: begin
            if (s == 0) begin
            end else if (s < 32) begin r = d << s; co = d[32-s]; end
            else if (s == 32) begin r = 32'd0; co = d[0]; end
            else begin r = 32'd0; co = 1'b0; end
         end
         2'b01: begin
            if (s == 0) begin
               if (!op[0]) begin r = 32'd0; co = d[31]; end
            end else if (s < 32) begin r = d >> s; co = d[s-1]; end
            else if (s == 32) begin r = 32'd0; co = d[31]; end
            else begin r = 32'd0; co = 1'b0; end
         end
         2'b10: begin
            if (s == 0) begin
               if (!op[0]) begin r = {32{d[31]}}; co = d[31]; end
            end else if (s < 32) begin r = $signed(d) >>> s; co = d[s-1]; end
            else begin r = {32{d[31]}}; co = d[31]; end
         end
         default: begin
            if (s == 0) begin
               if (!op[0]) begin r = {c, d[31:1]}; co = d[0]; end
            end else if ((s % 32) == 0) begin
               co = d[31];
            end else begin
               r  = (d >> (s % 32)) | (d << (32 - (s % 32)));
               co = r[31];
            end
         end
      endcase
      return {co, r};
   endfunction

   assign {a_Shift_Carry_Out, a_Shift_Out} = shf(a_SHIFT_OP, a_Shift_Data, a_Shift_Num, a_Carry_flag);

   always @(posedge clk) begin
      b_pipe1 <= shf(b_SHIFT_OP, b_Shift_Data, b_Shift_Num, b_Carry_flag);
      b_pipe2 <= b_pipe1;
   end
   assign {b_Shift_Carry_Out, b_Shift_Out} = b_pipe2;

   shift_arbiter #(.SHIFT_LAT(1)) dut_a (
      .clk(clk), .rst(rst),
      .Req0_Valid(a_Req0_Valid), .Req0_Ready(a_Req0_Ready), .Req0_Op(a_Req0_Op),
      .Req0_Data(a_Req0_Data), .Req0_Num(a_Req0_Num), .Req0_Carry(a_Req0_Carry),
      .Req1_Valid(a_Req1_Valid), .Req1_Ready(a_Req1_Ready), .Req1_Op(a_Req1_Op),
      .Req1_Data(a_Req1_Data), .Req1_Num(a_Req1_Num), .Req1_Carry(a_Req1_Carry),
      .Rsp0_Valid(a_Rsp0_Valid), .Rsp1_Valid(a_Rsp1_Valid), .Rsp_Out(a_Rsp_Out),
      .Rsp_Carry(a_Rsp_Carry), .Busy(a_Busy),
      .SHIFT_OP(a_SHIFT_OP), .Shift_Data(a_Shift_Data), .Shift_Num(a_Shift_Num),
      .Carry_flag(a_Carry_flag), .Shift_Out(a_Shift_Out), .Shift_Carry_Out(a_Shift_Carry_Out)
   );

   shift_arbiter #(.SHIFT_LAT(3)) dut_b (
      .clk(clk), .rst(rst),
      .Req0_Valid(b_Req0_Valid), .Req0_Ready(b_Req0_Ready), .Req0_Op(b_Req0_Op),
      .Req0_Data(b_Req0_Data), .Req0_Num(b_Req0_Num), .Req0_Carry(b_Req0_Carry),
      .Req1_Valid(b_Req1_Valid), .Req1_Ready(b_Req1_Ready), .Req1_Op(b_Req1_Op),
      .Req1_Data(b_Req1_Data), .Req1_Num(b_Req1_Num), .Req1_Carry(b_Req1_Carry),
      .Rsp0_Valid(b_Rsp0_Valid), .Rsp1_Valid(b_Rsp1_Valid), .Rsp_Out(b_Rsp_Out),
      .Rsp_Carry(b_Rsp_Carry), .Busy(b_Busy),
      .SHIFT_OP(b_SHIFT_OP), .Shift_Data(b_Shift_Data), .Shift_Num(b_Shift_Num),
      .Carry_flag(b_Carry_flag), .Shift_Out(b_Shift_Out), .Shift_Carry_Out(b_Shift_Carry_Out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int gseq[8];
   int ng;
   int rsp_cnt;
   int overlap;
   int stray;

   initial begin
      rst = 1'b1;
      a_Req0_Valid = 0; a_Req0_Op = 0; a_Req0_Data = 0; a_Req0_Num = 0; a_Req0_Carry = 0;
      a_Req1_Valid = 0; a_Req1_Op = 0; a_Req1_Data = 0; a_Req1_Num = 0; a_Req1_Carry = 0;
      b_Req0_Valid = 0; b_Req0_Op = 0; b_Req0_Data = 0; b_Req0_Num = 0; b_Req0_Carry = 0;
      b_Req1_Valid = 0; b_Req1_Op = 0; b_Req1_Data = 0; b_Req1_Num = 0; b_Req1_Carry = 0;
      tick();
      tick();

      // reset state
      a_Req0_Valid = 1;
      #1;
      chk("rst_ready0", a_Req0_Ready, 0);
      chk("rst_busy", a_Busy, 0);
      chk("rst_rsp", {a_Rsp0_Valid, a_Rsp1_Valid}, 0);
      chk("rst_out", {a_Rsp_Carry, a_Rsp_Out}, 0);
      chk("rst_shift", {a_SHIFT_OP, a_Shift_Data, a_Shift_Num, a_Carry_flag}, 0);
      a_Req0_Valid = 0;
      tick();
      rst = 1'b0;

      // requester 0 alone: LSL #4
      a_Req0_Valid = 1; a_Req0_Op = 3'b000; a_Req0_Data = 32'haaaaff00; a_Req0_Num = 8'h04;
      #1;
      chk("t1_ready0", a_Req0_Ready, 1);
      chk("t1_ready1", a_Req1_Ready, 0);
      chk("t1_busy_idle", a_Busy, 0);
      tick();
      a_Req0_Valid = 0;
      chk("t1_busy_wait", a_Busy, 1);
      chk("t1_no_rsp_yet", a_Rsp0_Valid, 0);
      chk("t1_shift_in", {a_SHIFT_OP, a_Shift_Data, a_Shift_Num}, {3'b000, 32'haaaaff00, 8'h04});
      tick();
      chk("t1_rsp0", a_Rsp0_Valid, 1);
      chk("t1_rsp1", a_Rsp1_Valid, 0);
      chk("t1_out", a_Rsp_Out, 32'haaaff000);
      chk("t1_carry", a_Rsp_Carry, 0);
      chk("t1_busy_resp", a_Busy, 1);
      tick();
      chk("t1_rsp0_end", a_Rsp0_Valid, 0);
      chk("t1_busy_end", a_Busy, 0);
      chk("t1_out_hold", a_Rsp_Out, 32'haaaff000);

      // both valid after reset: requester 0 first, then requester 1
      rst = 1'b1;
      tick();
      rst = 1'b0;
      a_Req0_Valid = 1; a_Req0_Op = 3'b010; a_Req0_Data = 32'haaaaff00; a_Req0_Num = 8'h04;
      a_Req1_Valid = 1; a_Req1_Op = 3'b111; a_Req1_Data = 32'haaaaff00; a_Req1_Num = 8'h10;
      #1;
      chk("t2_ready0", a_Req0_Ready, 1);
      chk("t2_ready1", a_Req1_Ready, 0);
      tick();
      a_Req0_Valid = 0;
      chk("t2_wait_noready", {a_Req0_Ready, a_Req1_Ready}, 0);
      tick();
      chk("t2_rsp_a", {a_Rsp0_Valid, a_Rsp1_Valid}, 2'b10);
      chk("t2_out_a", {a_Rsp_Carry, a_Rsp_Out}, {1'b0, 32'h0aaaaff0});
      tick();
      chk("t2_ready1_b", a_Req1_Ready, 1);
      tick();
      a_Req1_Valid = 0;
      tick();
      chk("t2_rsp_b", {a_Rsp0_Valid, a_Rsp1_Valid}, 2'b01);
      chk("t2_out_b", {a_Rsp_Carry, a_Rsp_Out}, {1'b1, 32'hff00aaaa});
      tick();

      // both held valid for six operations: strict alternation
      a_Req0_Valid = 1; a_Req0_Op = 3'b000; a_Req0_Data = 32'h00000011; a_Req0_Num = 8'h01;
      a_Req1_Valid = 1; a_Req1_Op = 3'b010; a_Req1_Data = 32'h00000022; a_Req1_Num = 8'h01;
      ng = 0; rsp_cnt = 0; overlap = 0;
      for (int cyc = 0; cyc < 40 && ng < 6; cyc++) begin
         #1;
         if (a_Rsp0_Valid && a_Rsp1_Valid) overlap++;
         if (a_Rsp0_Valid || a_Rsp1_Valid) rsp_cnt++;
         if (a_Req0_Ready && a_Req1_Ready) overlap++;
         if (a_Req0_Ready) begin gseq[ng] = 0; ng++; end
         else if (a_Req1_Ready) begin gseq[ng] = 1; ng++; end
         tick();
      end
      a_Req0_Valid = 0;
      a_Req1_Valid = 0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         if (a_Rsp0_Valid && a_Rsp1_Valid) overlap++;
         if (a_Rsp0_Valid || a_Rsp1_Valid) rsp_cnt++;
         tick();
      end
      chk("t3_grants", ng, 6);
      for (int i = 0; i < 6; i++) chk($sformatf("t3_grant%0d", i), gseq[i], i % 2);
      chk("t3_overlap", overlap, 0);
      chk("t3_rsp_count", rsp_cnt, 6);

      // RRX on requester 1
      a_Req1_Valid = 1; a_Req1_Op = 3'b110; a_Req1_Data = 32'haaaaff00; a_Req1_Num = 8'h00; a_Req1_Carry = 1;
      #1;
      chk("t4_ready1", a_Req1_Ready, 1);
      tick();
      a_Req1_Valid = 0;
      chk("t4_shift_in", {a_SHIFT_OP, a_Carry_flag}, {3'b110, 1'b1});
      tick();
      chk("t4_rsp", {a_Rsp0_Valid, a_Rsp1_Valid}, 2'b01);
      chk("t4_out", {a_Rsp_Carry, a_Rsp_Out}, {1'b0, 32'hd5557f80});
      tick();

      // asynchronous reset in the middle of WAIT
      a_Req0_Valid = 1; a_Req0_Op = 3'b101; a_Req0_Data = 32'h12345678; a_Req0_Num = 8'h03; a_Req0_Carry = 1;
      tick();
      a_Req0_Valid = 0;
      chk("t5_busy_before", a_Busy, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("t5_busy", a_Busy, 0);
      chk("t5_out", {a_Rsp_Carry, a_Rsp_Out}, 0);
      chk("t5_shift", {a_SHIFT_OP, a_Shift_Data, a_Shift_Num, a_Carry_flag}, 0);
      chk("t5_rsp", {a_Rsp0_Valid, a_Rsp1_Valid}, 0);
      tick();
      rst = 1'b0;
      stray = 0;
      for (int cyc = 0; cyc < 3; cyc++) begin
         if (a_Rsp0_Valid || a_Rsp1_Valid || a_Busy) stray++;
         tick();
      end
      chk("t5_no_stray_rsp", stray, 0);
      a_Req0_Valid = 1; a_Req0_Op = 3'b000; a_Req0_Data = 32'h81000001; a_Req0_Num = 8'h08; a_Req0_Carry = 0;
      a_Req1_Valid = 1; a_Req1_Op = 3'b011; a_Req1_Data = 32'hffffffff; a_Req1_Num = 8'h02;
      #1;
      chk("t5_rr_reset", {a_Req0_Ready, a_Req1_Ready}, 2'b10);
      tick();
      a_Req0_Valid = 0;
      a_Req1_Valid = 0;
      tick();
      chk("t5_rsp_after", {a_Rsp0_Valid, a_Rsp1_Valid}, 2'b10);
      chk("t5_out_after", {a_Rsp_Carry, a_Rsp_Out}, {1'b1, 32'h00000100});
      tick();
      chk("t5_drop_no_grant", {a_Req1_Ready, a_Busy}, 0);

      // SHIFT_LAT=3: LSR reg #8
      b_Req1_Valid = 1; b_Req1_Op = 3'b011; b_Req1_Data = 32'h000001ff; b_Req1_Num = 8'h08;
      #1;
      chk("t6_ready1", b_Req1_Ready, 1);
      tick();
      b_Req1_Valid = 0;
      chk("t6_busy", b_Busy, 1);
      for (int cyc = 1; cyc <= 2; cyc++) begin
         tick();
         chk($sformatf("t6_no_rsp_e%0d", cyc), {b_Rsp0_Valid, b_Rsp1_Valid}, 0);
      end
      tick();
      chk("t6_rsp", {b_Rsp0_Valid, b_Rsp1_Valid}, 2'b01);
      chk("t6_out", {b_Rsp_Carry, b_Rsp_Out}, {1'b1, 32'h00000001});
      tick();
      chk("t6_done", {b_Rsp1_Valid, b_Busy}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
